autoconfig_host: RTL and testbench
==================================

AUTOCONFIG_HOST -- requirements
Module: autoconfig_host

Interface
REQ-001 Parameter TIMEOUT, default 32: max CLK cycles to wait for _DTACK per bus cycle.
REQ-002 Parameter MAX_BOARDS, default 8: max boards configured per run.
REQ-003 Parameter MEM_LO / MEM_HI, defaults 8'h20 / 8'hA0: memory pool, A[23:16] units, HI exclusive.
REQ-004 Parameter IO_LO / IO_HI, defaults 8'hE9 / 8'hF0: I/O pool, A[23:16] units, HI exclusive.
REQ-005 CLK  in  1  single system clock; all logic on rising edge.
REQ-006 _RESET  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse; begins a run when idle.
REQ-008 _DTACK  in  1  bus acknowledge, asynchronous, active-low.
REQ-009 D_in  in  4  read nibble from D[15:12].
REQ-010 A  out  23  address A[23:1].
REQ-011 _AS, _UDS  out  1 each  strobes, active-low; _LDS held high.
REQ-012 R_W  out  1  1 = read.
REQ-013 D_out  out  4  write nibble for D[15:12]; D_oe  out  1  drive enable.
REQ-014 busy, done  out  1 each  run active; one-cycle end-of-run pulse.
REQ-015 board_cnt  out  4  boards configured this run.
REQ-016 last_base  out  8  A[23:16] last assigned; shutup  out  1  sticky, a board was shut up.

Function
REQ-017 Bus cycle engine: states B_IDLE -> B_ADDR (A, R_W, D_out/D_oe valid, strobes high, 1 cycle) -> B_STRB (_AS, _UDS low) -> B_WAIT -> B_END (strobes high, 1 cycle) -> B_IDLE.
REQ-018 _DTACK passes a 2-flop synchroniser; B_WAIT exits on synchronised low, latching D_in that cycle for reads.
REQ-019 B_WAIT counter reaching TIMEOUT without _DTACK -> B_END with timeout flag; strobes never stay asserted longer than TIMEOUT+1 cycles.
REQ-020 D_oe only in B_ADDR..B_END of write cycles; R_W low only in write cycles.
REQ-021 Run sequencer states: IDLE, RD_T0, RD_T1, DECIDE, WR_LO, WR_HI, WR_SHUT, NEXT, FINISH.
REQ-022 IDLE + start -> RD_T0; start ignored while busy.
REQ-023 RD_T0 reads $E80000 (er_Type[7:4]); RD_T1 reads $E80002 (er_Type[3:0]); both un-inverted.
REQ-024 Timeout in RD_T0 or RD_T1 = no unconfigured board -> FINISH.
REQ-025 DECIDE: er_Type[7:6] != 2'b11 -> WR_SHUT; size code er_Type[2:0]: 000=128, 001=1, 010=2, 011=4, 100=8, 101=16, 110=32, 111=64 units.
REQ-026 er_Type[5]=1 selects memory pool pointer, else I/O pool pointer.
REQ-027 Candidate base = pointer rounded up to multiple of size; fits iff candidate+size <= pool HI, computed 9 bits wide, no wrap.
REQ-028 Fit -> WR_LO writes candidate[3:0] to $E8004A, then WR_HI writes candidate[7:4] to $E80048; pointer := candidate+size; last_base := candidate; board_cnt +1.
REQ-029 No fit -> WR_SHUT writes 4'h0 to $E8004C; shutup := 1; pointers unchanged.
REQ-030 Write-cycle timeout ignored; sequencer proceeds.
REQ-031 NEXT -> RD_T0 if boards handled (configured + shut up) < MAX_BOARDS, else FINISH.
REQ-032 FINISH: done high one cycle, busy low, -> IDLE; board_cnt, last_base, shutup held until next start.
REQ-033 New start clears board_cnt, shutup, last_base, resets pointers to MEM_LO / IO_LO.

Reset
REQ-034 _RESET low asynchronously forces: both FSMs idle, _AS=_UDS=_LDS=R_W=1, D_oe=0, D_out=0, A=0, busy=done=shutup=0, board_cnt=0, last_base=0, pointers to LO values, synchroniser flops to 1.
REQ-035 Reset mid-cycle releases strobes and D_oe in the same asynchronous event; no cycle resumes after release.

Verification
REQ-036 No responder, start -> one read of $E80000, strobes low TIMEOUT+1 cycles, done; board_cnt=0.
REQ-037 One memory board er_Type=8'hE6 (2 MB) -> writes $4A=0, $48=2; last_base=8'h20; board_cnt=1.
REQ-038 Memory boards 8'hE1 (64 KB) then 8'hE5 (1 MB) -> bases 8'h20, 8'h30 (aligned); board_cnt=2.
REQ-039 I/O board 8'hC1 -> base 8'hE9; memory board 8'hE0 (8 MB) after a 64 KB board -> no fit, write $E8004C, shutup=1.
REQ-040 _RESET low while _AS low in B_WAIT -> _AS, _UDS high and D_oe low immediately; start after release runs cleanly from RD_T0.

Source files
------------

// File: rtl/autoconfig_host.sv
// Zorro-II style AutoConfig host: probes the config slot, assigns bases from memory/IO pools, shuts up misfits.
// Latency: each bus cycle is 1 addr + 1 strobe + wait (sync'd _DTACK, max TIMEOUT) + 1 end cycle; done pulses one cycle after the run ends.
// Backpressure: bus cycles stall on _DTACK up to TIMEOUT cycles; start is ignored while busy.
module autoconfig_host #(
    parameter int         TIMEOUT    = 32,
    parameter int         MAX_BOARDS = 8,
    parameter logic [7:0] MEM_LO     = 8'h20,
    parameter logic [7:0] MEM_HI     = 8'hA0,
    parameter logic [7:0] IO_LO      = 8'hE9,
    parameter logic [7:0] IO_HI      = 8'hF0
) (
    input  logic        CLK,
    input  logic        _RESET,
    input  logic        start,
    input  logic        _DTACK,
    input  logic [3:0]  D_in,
    output logic [23:1] A,
    output logic        _AS,
    output logic        _UDS,
    output logic        _LDS,
    output logic        R_W,
    output logic [3:0]  D_out,
    output logic        D_oe,
    output logic        busy,
    output logic        done,
    output logic [3:0]  board_cnt,
    output logic [7:0]  last_base,
    output logic        shutup
);

    // Config-space word addresses (A[23:1]) of the er_Type nibbles and the base/shutup registers.
    localparam logic [22:0] ADDR_T0   = 23'h740000;  // $E80000
    localparam logic [22:0] ADDR_T1   = 23'h740001;  // $E80002
    localparam logic [22:0] ADDR_HI   = 23'h740024;  // $E80048
    localparam logic [22:0] ADDR_LO   = 23'h740025;  // $E8004A
    localparam logic [22:0] ADDR_SHUT = 23'h740026;  // $E8004C

    localparam int          TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]  MAXB  = 8'(MAX_BOARDS);

    typedef enum logic [2:0] {B_IDLE, B_ADDR, B_STRB, B_WAIT, B_END} bus_state_t;
    typedef enum logic [3:0] {IDLE, RD_T0, RD_T1, DECIDE, WR_LO, WR_HI, WR_SHUT, NEXT, FINISH} seq_state_t;

    bus_state_t  bstate;
    seq_state_t  sstate;

    logic          dtack_s1, dtack_s2;
    logic [TW-1:0] wait_cnt;

    // Request/response handshake between sequencer and bus engine.
    logic          bus_req;
    logic          bus_rw;
    logic [22:0]   bus_addr;
    logic [3:0]    bus_wdat;
    logic          bus_done;
    logic          bus_tmo;
    logic [3:0]    bus_rdat;

    logic [7:0]    er_type;
    logic [7:0]    mem_ptr, io_ptr;
    logic [7:0]    cand_q;
    logic [7:0]    handled;

    logic [8:0]    size9, ptr9, hi9, cand9;
    logic          fits;

    assign _LDS = 1'b1;

    // Board size, aligned candidate base and pool fit, all 9 bits wide so nothing wraps.
    always_comb begin
        size9 = (er_type[2:0] == 3'd0) ? 9'd128 : (9'd1 << (er_type[2:0] - 3'd1));
        ptr9  = {1'b0, er_type[5] ? mem_ptr : io_ptr};
        hi9   = {1'b0, er_type[5] ? MEM_HI : IO_HI};
        cand9 = (ptr9 + size9 - 9'd1) & ~(size9 - 9'd1);
        fits  = (cand9 + size9) <= hi9;
    end

    // Two-flop synchroniser for the asynchronous bus acknowledge.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            dtack_s1 <= 1'b1;
            dtack_s2 <= 1'b1;
        end else begin
            dtack_s1 <= _DTACK;
            dtack_s2 <= dtack_s1;
        end
    end

    // Bus cycle engine: address setup, strobes, bounded wait for acknowledge, strobe release.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            bstate   <= B_IDLE;
            A        <= '0;
            _AS      <= 1'b1;
            _UDS     <= 1'b1;
            R_W      <= 1'b1;
            D_out    <= 4'h0;
            D_oe     <= 1'b0;
            wait_cnt <= '0;
            bus_done <= 1'b0;
            bus_tmo  <= 1'b0;
            bus_rdat <= 4'h0;
        end else begin
            bus_done <= 1'b0;
            case (bstate)
                B_IDLE: begin
                    if (bus_req) begin
                        A       <= bus_addr;
                        R_W     <= bus_rw;
                        D_out   <= bus_rw ? 4'h0 : bus_wdat;
                        D_oe    <= !bus_rw;
                        bus_tmo <= 1'b0;
                        bstate  <= B_ADDR;
                    end
                end
                B_ADDR: begin
                    _AS    <= 1'b0;
                    _UDS   <= 1'b0;
                    bstate <= B_STRB;
                end
                B_STRB: begin
                    wait_cnt <= '0;
                    bstate   <= B_WAIT;
                end
                B_WAIT: begin
                    if (!dtack_s2) begin
                        if (R_W) bus_rdat <= D_in;
                        _AS    <= 1'b1;
                        _UDS   <= 1'b1;
                        bstate <= B_END;
                    end else if (wait_cnt == TLAST) begin
                        bus_tmo <= 1'b1;
                        _AS     <= 1'b1;
                        _UDS    <= 1'b1;
                        bstate  <= B_END;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                B_END: begin
                    R_W      <= 1'b1;
                    D_oe     <= 1'b0;
                    bus_done <= 1'b1;
                    bstate   <= B_IDLE;
                end
                default: bstate <= B_IDLE;
            endcase
        end
    end

    // Run sequencer: read er_Type, place or shut up each board, repeat until the chain is empty or full.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            sstate    <= IDLE;
            bus_req   <= 1'b0;
            bus_rw    <= 1'b1;
            bus_addr  <= '0;
            bus_wdat  <= 4'h0;
            er_type   <= 8'h00;
            mem_ptr   <= MEM_LO;
            io_ptr    <= IO_LO;
            cand_q    <= 8'h00;
            handled   <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            board_cnt <= 4'h0;
            last_base <= 8'h00;
            shutup    <= 1'b0;
        end else begin
            bus_req <= 1'b0;
            done    <= 1'b0;
            case (sstate)
                IDLE: begin
                    if (start) begin
                        mem_ptr   <= MEM_LO;
                        io_ptr    <= IO_LO;
                        handled   <= 8'h00;
                        board_cnt <= 4'h0;
                        last_base <= 8'h00;
                        shutup    <= 1'b0;
                        busy      <= 1'b1;
                        bus_req   <= 1'b1;
                        bus_rw    <= 1'b1;
                        bus_addr  <= ADDR_T0;
                        bus_wdat  <= 4'h0;
                        sstate    <= RD_T0;
                    end
                end
                RD_T0: begin
                    if (bus_done) begin
                        if (bus_tmo) begin
                            sstate <= FINISH;
                        end else begin
                            er_type[7:4] <= bus_rdat;
                            bus_req      <= 1'b1;
                            bus_rw       <= 1'b1;
                            bus_addr     <= ADDR_T1;
                            sstate       <= RD_T1;
                        end
                    end
                end
                RD_T1: begin
                    if (bus_done) begin
                        if (bus_tmo) begin
                            sstate <= FINISH;
                        end else begin
                            er_type[3:0] <= bus_rdat;
                            sstate       <= DECIDE;
                        end
                    end
                end
                DECIDE: begin
                    bus_req <= 1'b1;
                    bus_rw  <= 1'b0;
                    if (er_type[7:6] != 2'b11 || !fits) begin
                        bus_addr <= ADDR_SHUT;
                        bus_wdat <= 4'h0;
                        sstate   <= WR_SHUT;
                    end else begin
                        cand_q   <= cand9[7:0];
                        bus_addr <= ADDR_LO;
                        bus_wdat <= cand9[3:0];
                        sstate   <= WR_LO;
                    end
                end
                WR_LO: begin
                    if (bus_done) begin
                        bus_req  <= 1'b1;
                        bus_rw   <= 1'b0;
                        bus_addr <= ADDR_HI;
                        bus_wdat <= cand_q[7:4];
                        sstate   <= WR_HI;
                    end
                end
                WR_HI: begin
                    if (bus_done) begin
                        if (er_type[5]) mem_ptr <= cand_q + size9[7:0];
                        else            io_ptr  <= cand_q + size9[7:0];
                        last_base <= cand_q;
                        board_cnt <= board_cnt + 4'd1;
                        handled   <= handled + 8'd1;
                        sstate    <= NEXT;
                    end
                end
                WR_SHUT: begin
                    if (bus_done) begin
                        shutup  <= 1'b1;
                        handled <= handled + 8'd1;
                        sstate  <= NEXT;
                    end
                end
                NEXT: begin
                    if (handled < MAXB) begin
                        bus_req  <= 1'b1;
                        bus_rw   <= 1'b1;
                        bus_addr <= ADDR_T0;
                        bus_wdat <= 4'h0;
                        sstate   <= RD_T0;
                    end else begin
                        sstate <= FINISH;
                    end
                end
                FINISH: begin
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    sstate <= IDLE;
                end
                default: sstate <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_autoconfig_host.sv
// Bench for autoconfig_host: a behavioural chain of AutoConfig boards answers the bus,
// table-driven runs compare write logs and result registers, plus reset sequences.
// Runs are bounded by cycle budgets and a global watchdog.
module tb_autoconfig_host;

    localparam int TIMEOUT = 32;

    logic        CLK = 1'b0;
    logic        _RESET = 1'b0;
    logic        start = 1'b0;
    logic        _DTACK = 1'b1;
    logic [3:0]  D_in = 4'h0;
    logic [23:1] A;
    logic        _AS, _UDS, _LDS, R_W;
    logic [3:0]  D_out;
    logic        D_oe, busy, done;
    logic [3:0]  board_cnt;
    logic [7:0]  last_base;
    logic        shutup;

    autoconfig_host #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), ._RESET(_RESET), .start(start), ._DTACK(_DTACK), .D_in(D_in),
        .A(A), ._AS(_AS), ._UDS(_UDS), ._LDS(_LDS), .R_W(R_W),
        .D_out(D_out), .D_oe(D_oe), .busy(busy), .done(done),
        .board_cnt(board_cnt), .last_base(last_base), .shutup(shutup)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Board chain model and bus monitor.
    logic [7:0]  boards [2];
    int          nb = 0;
    int          bidx = 0;
    bit          ack_writes = 1'b1;
    logic        prev_as = 1'b1;
    int          low_run = 0;
    int          max_low = 0;
    int          reads = 0;
    int          viol = 0;
    bit          got_first = 1'b0;
    logic [22:0] first_a = '0;
    logic [26:0] wlog [$];

    // Acknowledge on the falling clock edge: reads only while a board remains, writes when enabled.
    always @(negedge CLK) begin
        if (!_AS) begin
            low_run++;
            if (low_run > max_low) max_low = low_run;
            if (prev_as) begin
                if (!got_first) begin
                    got_first = 1'b1;
                    first_a = A;
                end
                if (!R_W) begin
                    wlog.push_back({A, D_out});
                    if (A == 23'h740024 || A == 23'h740026) bidx++;
                end else begin
                    reads++;
                end
            end
            if (!R_W) begin
                if (ack_writes) _DTACK = 1'b0;
            end else if (bidx < nb) begin
                _DTACK = 1'b0;
                D_in = (A == 23'h740000) ? boards[bidx][7:4] : boards[bidx][3:0];
            end
        end else begin
            low_run = 0;
            _DTACK = 1'b1;
        end
        if (D_oe && R_W) viol++;
        if (!_LDS) viol++;
        prev_as = _AS;
    end

    // Expected write byte: [7:6] selects register (0=$4A, 1=$48, 2=$4C), [3:0] data.
    function automatic logic [26:0] exp_w(input logic [7:0] e);
        case (e[7:6])
            2'd0:    return {23'h740025, e[3:0]};
            2'd1:    return {23'h740024, e[3:0]};
            default: return {23'h740026, e[3:0]};
        endcase
    endfunction

    typedef struct {
        int               nb;
        logic [7:0]       t0;
        logic [7:0]       t1;
        int               exp_cnt;
        logic [7:0]       exp_base;
        logic             exp_shut;
        int               nw;
        logic [0:5][7:0]  w;
    } vec_t;

    vec_t vecs [7];

    task automatic clear_mon();
        wlog.delete();
        reads = 0;
        max_low = 0;
        got_first = 1'b0;
        bidx = 0;
    endtask

    task automatic pulse_start();
        @(posedge CLK);
        #1 start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{0, 8'h00, 8'h00, 0, 8'h00, 1'b0, 0, 48'h00_00_00_00_00_00};
        vecs[1] = '{1, 8'hE6, 8'h00, 1, 8'h20, 1'b0, 2, 48'h00_42_00_00_00_00};
        vecs[2] = '{2, 8'hE1, 8'hE5, 2, 8'h30, 1'b0, 4, 48'h00_42_00_43_00_00};
        vecs[3] = '{1, 8'hC1, 8'h00, 1, 8'hE9, 1'b0, 2, 48'h09_4E_00_00_00_00};
        vecs[4] = '{2, 8'hE1, 8'hE0, 1, 8'h20, 1'b1, 3, 48'h00_42_80_00_00_00};
        vecs[5] = '{1, 8'h41, 8'h00, 0, 8'h00, 1'b1, 1, 48'h80_00_00_00_00_00};
        vecs[6] = '{2, 8'hC3, 8'hC2, 1, 8'hEC, 1'b1, 3, 48'h0C_4E_80_00_00_00};

        // Reset state.
        repeat (3) @(negedge CLK);
        chk("rst_as", _AS, 1);
        chk("rst_uds", _UDS, 1);
        chk("rst_lds", _LDS, 1);
        chk("rst_rw", R_W, 1);
        chk("rst_doe", D_oe, 0);
        chk("rst_dout", D_out, 0);
        chk("rst_a", A, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", board_cnt, 0);
        chk("rst_base", last_base, 0);
        chk("rst_shut", shutup, 0);
        @(posedge CLK);
        #1 _RESET = 1'b1;

        // Reset asserted mid-write while strobes are low and the board never acknowledges.
        nb = 1;
        boards[0] = 8'hE6;
        ack_writes = 1'b0;
        clear_mon();
        pulse_start();
        n = 0;
        while (!(!_AS && D_oe) && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        chk("midrst_reach_write", (!_AS && D_oe), 1);
        repeat (4) @(negedge CLK);
        chk("midrst_pre_as", _AS, 0);
        #2 _RESET = 1'b0;
        #1;
        chk("midrst_as", _AS, 1);
        chk("midrst_uds", _UDS, 1);
        chk("midrst_doe", D_oe, 0);
        chk("midrst_rw", R_W, 1);
        chk("midrst_busy", busy, 0);
        repeat (2) @(posedge CLK);
        #1 _RESET = 1'b1;
        ack_writes = 1'b1;
        clear_mon();
        repeat (50) @(negedge CLK);
        chk("midrst_no_resume", reads + wlog.size(), 0);
        chk("midrst_idle_busy", busy, 0);

        // Start pulse while busy must not restart the run.
        nb = 0;
        clear_mon();
        pulse_start();
        repeat (10) @(negedge CLK);
        pulse_start();
        n = 0;
        while (!done && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        chk("busy_start_done", done, 1);
        chk("busy_start_reads", reads, 1);

        // Table-driven runs.
        for (int v = 0; v < 7; v++) begin
            nb = vecs[v].nb;
            boards[0] = vecs[v].t0;
            boards[1] = vecs[v].t1;
            clear_mon();
            pulse_start();
            chk($sformatf("v%0d_busy", v), busy, 1);
            n = 0;
            while (!done && n < 3000) begin
                @(negedge CLK);
                n++;
            end
            chk($sformatf("v%0d_done", v), done, 1);
            chk($sformatf("v%0d_busy_end", v), busy, 0);
            chk($sformatf("v%0d_cnt", v), board_cnt, vecs[v].exp_cnt);
            chk($sformatf("v%0d_base", v), last_base, vecs[v].exp_base);
            chk($sformatf("v%0d_shut", v), shutup, vecs[v].exp_shut);
            chk($sformatf("v%0d_reads", v), reads, 2 * vecs[v].nb + 1);
            chk($sformatf("v%0d_first_a", v), first_a, 23'h740000);
            chk($sformatf("v%0d_strobe_max", v), max_low, TIMEOUT + 1);
            chk($sformatf("v%0d_nwrites", v), wlog.size(), vecs[v].nw);
            for (int i = 0; i < vecs[v].nw; i++) begin
                if (i < wlog.size())
                    chk($sformatf("v%0d_w%0d", v, i), wlog[i], exp_w(vecs[v].w[i]));
            end
            @(negedge CLK);
            chk($sformatf("v%0d_done_pulse", v), done, 0);
            repeat (5) @(negedge CLK);
            chk($sformatf("v%0d_cnt_hold", v), board_cnt, vecs[v].exp_cnt);
        end

        chk("bus_rules", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
